// File: rtl/mfcc_pkg.sv
// Shared state/error encodings and default sizing for the MFCC frame sequencer.
package mfcc_pkg;

  localparam int DEF_NUM_CEPS   = 12;
  localparam int DEF_CEPS_WIDTH = 16;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_FRAME,
    START,
    WAIT_HAM,
    WAIT_FFT,
    WAIT_MEL,
    WAIT_DCT,
    DRAIN,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_SEQ     = 2'b10,
    ERR_MISSING = 2'b11
  } err_t;

endpackage

// File: rtl/mfcc_watchdog.sv
// Saturating cycle watchdog: flags expiry on the LIMIT-th counted cycle since the last clear.
module mfcc_watchdog
  import mfcc_pkg::*;
#(
  parameter int LIMIT = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is combinational so the owner can leave on exactly the LIMIT-th cycle.
  assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// One-frame-in-flight controller for the MFCC chain: starts frames, tracks stage
// done strobes in order, captures the cepstral coefficients and drains them over valid/ready.
module mfcc_frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int NUM_CEPS        = DEF_NUM_CEPS,
  parameter int CEPS_WIDTH      = DEF_CEPS_WIDTH,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int FRAME_CNT_WIDTH = 16,
  localparam int IDX_W          = (NUM_CEPS > 1) ? $clog2(NUM_CEPS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic                       frame_ready_i,
  output logic                       start_frame_o,
  input  logic                       hamming_done_i,
  input  logic                       fft_done_i,
  input  logic                       mel_done_i,
  input  logic                       dct_done_i,
  input  logic                       dct_valid_i,
  input  logic [IDX_W-1:0]           ceps_ptr_i,
  input  logic [CEPS_WIDTH-1:0]      ceps_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CEPS_WIDTH-1:0]      out_data_o,
  output logic [IDX_W-1:0]           out_idx_o,
  output logic                       out_last_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count_o,
  output logic                       busy_o,
  output logic                       error_o,
  output logic [1:0]                 error_code_o
);

  state_t                     state_q, state_d;
  err_t                       errCode_q, errCode_d;
  logic [IDX_W-1:0]           outIdx_q, outIdx_d;
  logic [FRAME_CNT_WIDTH-1:0] frameCount_q, frameCount_d;
  logic [NUM_CEPS-1:0]        mask_q, mask_d;
  logic [NUM_CEPS-1:0]        capBit;
  logic [CEPS_WIDTH-1:0]      ceps_q [NUM_CEPS];

  logic capWrite;
  logic handshake;
  logic lastBeat;
  logic wdClear;
  logic wdCount;
  logic wdExpired;

  assign capWrite  = (state_q == WAIT_DCT) && dct_valid_i && (32'(ceps_ptr_i) < NUM_CEPS);
  assign handshake = out_valid_o && out_ready_i;
  assign lastBeat  = (outIdx_q == IDX_W'(NUM_CEPS - 1));

  // Only stage waits and stalled drain beats are watched; WAIT_FRAME may idle forever.
  assign wdCount = ((state_q == WAIT_HAM) || (state_q == WAIT_FFT) ||
                    (state_q == WAIT_MEL) || (state_q == WAIT_DCT)) ||
                   ((state_q == DRAIN) && !out_ready_i);
  assign wdClear = (state_d != state_q);

  mfcc_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wdClear),
    .count_i  (wdCount),
    .expired_o(wdExpired)
  );

  always_comb begin
    capBit = '0;
    for (int i = 0; i < NUM_CEPS; i++) begin
      if (capWrite && (32'(ceps_ptr_i) == i)) capBit[i] = 1'b1;
    end
  end

  // A foreign done strobe outranks the own one, and both outrank the watchdog.
  always_comb begin
    state_d      = state_q;
    errCode_d    = errCode_q;
    mask_d       = mask_q | capBit;
    frameCount_d = frameCount_q;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!enable_i) state_d = IDLE;
        else if (frame_ready_i) state_d = START;
      end
      START: begin
        mask_d  = '0;
        state_d = WAIT_HAM;
      end
      WAIT_HAM: begin
        if (fft_done_i || mel_done_i || dct_done_i) begin
          state_d = ERROR; errCode_d = ERR_SEQ;
        end else if (hamming_done_i) begin
          state_d = WAIT_FFT;
        end else if (wdExpired) begin
          state_d = ERROR; errCode_d = ERR_TIMEOUT;
        end
      end
      WAIT_FFT: begin
        if (hamming_done_i || mel_done_i || dct_done_i) begin
          state_d = ERROR; errCode_d = ERR_SEQ;
        end else if (fft_done_i) begin
          state_d = WAIT_MEL;
        end else if (wdExpired) begin
          state_d = ERROR; errCode_d = ERR_TIMEOUT;
        end
      end
      WAIT_MEL: begin
        if (hamming_done_i || fft_done_i || dct_done_i) begin
          state_d = ERROR; errCode_d = ERR_SEQ;
        end else if (mel_done_i) begin
          state_d = WAIT_DCT;
        end else if (wdExpired) begin
          state_d = ERROR; errCode_d = ERR_TIMEOUT;
        end
      end
      WAIT_DCT: begin
        if (hamming_done_i || fft_done_i || mel_done_i) begin
          state_d = ERROR; errCode_d = ERR_SEQ;
        end else if (dct_done_i) begin
          if (&(mask_q | capBit)) begin
            state_d = DRAIN;
          end else begin
            state_d = ERROR; errCode_d = ERR_MISSING;
          end
        end else if (wdExpired) begin
          state_d = ERROR; errCode_d = ERR_TIMEOUT;
        end
      end
      DRAIN: begin
        if (handshake && lastBeat) begin
          frameCount_d = frameCount_q + FRAME_CNT_WIDTH'(1);
          state_d      = enable_i ? WAIT_FRAME : IDLE;
        end else if (wdExpired) begin
          state_d = ERROR; errCode_d = ERR_TIMEOUT;
        end
      end
      ERROR: begin
        if (!enable_i) begin
          state_d   = IDLE;
          errCode_d = ERR_NONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The index only lives inside DRAIN, so it is zero whenever DRAIN is left.
  always_comb begin
    outIdx_d = '0;
    if (state_d == DRAIN) outIdx_d = handshake ? (outIdx_q + IDX_W'(1)) : outIdx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      errCode_q    <= ERR_NONE;
      outIdx_q     <= '0;
      frameCount_q <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      errCode_q    <= errCode_d;
      outIdx_q     <= outIdx_d;
      frameCount_q <= frameCount_d;
      mask_q       <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capWrite) ceps_q[ceps_ptr_i] <= ceps_i;
  end

  assign start_frame_o = (state_q == START);
  assign out_valid_o   = (state_q == DRAIN);
  assign out_data_o    = out_valid_o ? ceps_q[outIdx_q] : '0;
  assign out_idx_o     = outIdx_q;
  assign out_last_o    = out_valid_o && lastBeat;
  assign frame_count_o = frameCount_q;
  assign busy_o        = (state_q != IDLE) && (state_q != ERROR);
  assign error_o       = (state_q == ERROR);
  assign error_code_o  = errCode_q;

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Directed bench for mfcc_frame_sequencer with a 64-cycle watchdog: nominal, backpressure,
// timeout, sequence, missing-coefficient, stop-after-frame and async-reset scenarios.
module tb_mfcc_frame_sequencer;

  localparam int NUM_CEPS   = 12;
  localparam int CEPS_WIDTH = 16;
  localparam int TIMEOUT    = 64;
  localparam int FCW        = 16;
  localparam int IDX_W      = 4;

  logic                  clk;
  logic                  rst;
  logic                  enable_i;
  logic                  frame_ready_i;
  logic                  start_frame_o;
  logic                  hamming_done_i;
  logic                  fft_done_i;
  logic                  mel_done_i;
  logic                  dct_done_i;
  logic                  dct_valid_i;
  logic [IDX_W-1:0]      ceps_ptr_i;
  logic [CEPS_WIDTH-1:0] ceps_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [CEPS_WIDTH-1:0] out_data_o;
  logic [IDX_W-1:0]      out_idx_o;
  logic                  out_last_o;
  logic [FCW-1:0]        frame_count_o;
  logic                  busy_o;
  logic                  error_o;
  logic [1:0]            error_code_o;

  int testsRun    = 0;
  int testsFailed = 0;
  int startCount  = 0;

  mfcc_frame_sequencer #(
    .NUM_CEPS       (NUM_CEPS),
    .CEPS_WIDTH     (CEPS_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .frame_ready_i (frame_ready_i),
    .start_frame_o (start_frame_o),
    .hamming_done_i(hamming_done_i),
    .fft_done_i    (fft_done_i),
    .mel_done_i    (mel_done_i),
    .dct_done_i    (dct_done_i),
    .dct_valid_i   (dct_valid_i),
    .ceps_ptr_i    (ceps_ptr_i),
    .ceps_i        (ceps_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_idx_o     (out_idx_o),
    .out_last_o    (out_last_o),
    .frame_count_o (frame_count_o),
    .busy_o        (busy_o),
    .error_o       (error_o),
    .error_code_o  (error_code_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (start_frame_o === 1'b1) startCount++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of strobes, lets the DUT sample them, then returns all strobes low.
  task automatic applyStimulus(input logic ham, input logic fft, input logic mel, input logic dct,
                               input logic valid, input logic [IDX_W-1:0] ptr,
                               input logic [CEPS_WIDTH-1:0] data);
    hamming_done_i = ham;
    fft_done_i     = fft;
    mel_done_i     = mel;
    dct_done_i     = dct;
    dct_valid_i    = valid;
    ceps_ptr_i     = ptr;
    ceps_i         = data;
    step(1);
    hamming_done_i = 1'b0;
    fft_done_i     = 1'b0;
    mel_done_i     = 1'b0;
    dct_done_i     = 1'b0;
    dct_valid_i    = 1'b0;
    ceps_ptr_i     = '0;
    ceps_i         = '0;
  endtask

  // From WAIT_HAM through to DRAIN; the last write shares its cycle with dct_done.
  task automatic runStages(input logic [CEPS_WIDTH-1:0] base, input logic dropAtMel);
    step(9);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    step(9);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    if (dropAtMel) begin
      enable_i = 1'b0;
      step(3);
      checkOutput("stop_busy_in_mel", 32'(busy_o), 32'd1);
    end else begin
      step(9);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    for (int p = 0; p < NUM_CEPS - 1; p++) begin
      applyStimulus(0, 0, 0, 0, 1, IDX_W'(p), base + CEPS_WIDTH'(p));
    end
    applyStimulus(0, 0, 0, 1, 1, IDX_W'(NUM_CEPS - 1), base + CEPS_WIDTH'(NUM_CEPS - 1));
  endtask

  task automatic drainFull(input string tag, input logic [CEPS_WIDTH-1:0] base);
    out_ready_i = 1'b1;
    for (int i = 0; i < NUM_CEPS; i++) begin
      checkOutput($sformatf("%s_valid%0d", tag, i), 32'(out_valid_o), 32'd1);
      checkOutput($sformatf("%s_idx%0d", tag, i), 32'(out_idx_o), 32'(i));
      checkOutput($sformatf("%s_data%0d", tag, i), 32'(out_data_o), 32'(base) + 32'(i));
      checkOutput($sformatf("%s_last%0d", tag, i), 32'(out_last_o), (i == NUM_CEPS - 1) ? 32'd1 : 32'd0);
      step(1);
    end
    checkOutput({tag, "_valid_after"}, 32'(out_valid_o), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start"}, 32'(start_frame_o), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    checkOutput({tag, "_data"}, 32'(out_data_o), 32'd0);
    checkOutput({tag, "_idx"}, 32'(out_idx_o), 32'd0);
    checkOutput({tag, "_last"}, 32'(out_last_o), 32'd0);
    checkOutput({tag, "_count"}, 32'(frame_count_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_error"}, 32'(error_o), 32'd0);
    checkOutput({tag, "_code"}, 32'(error_code_o), 32'd0);
  endtask

  initial begin
    logic [3:0] readyPat;
    int expIdx;
    int cyc;

    rst = 1'b1;
    enable_i = 1'b0;
    frame_ready_i = 1'b0;
    hamming_done_i = 1'b0;
    fft_done_i = 1'b0;
    mel_done_i = 1'b0;
    dct_done_i = 1'b0;
    dct_valid_i = 1'b0;
    ceps_ptr_i = '0;
    ceps_i = '0;
    out_ready_i = 1'b0;

    step(2);
    checkAllZero("reset");
    rst = 1'b0;
    step(1);

    // Nominal frame
    enable_i = 1'b1;
    frame_ready_i = 1'b1;
    step(1);
    checkOutput("nom_wait_frame_busy", 32'(busy_o), 32'd1);
    checkOutput("nom_no_start_yet", 32'(start_frame_o), 32'd0);
    step(1);
    checkOutput("nom_start_pulse", 32'(start_frame_o), 32'd1);
    frame_ready_i = 1'b0;
    step(1);
    checkOutput("nom_start_one_cycle", 32'(start_frame_o), 32'd0);
    out_ready_i = 1'b1;
    runStages(16'h0100, 1'b0);
    drainFull("nom", 16'h0100);
    checkOutput("nom_frame_count", 32'(frame_count_o), 32'd1);
    checkOutput("nom_back_to_wait_busy", 32'(busy_o), 32'd1);
    checkOutput("nom_start_count", 32'(startCount), 32'd1);

    // Backpressure with frame_ready held high throughout
    frame_ready_i = 1'b1;
    out_ready_i = 1'b0;
    step(1);
    checkOutput("bp_start_pulse", 32'(start_frame_o), 32'd1);
    step(1);
    runStages(16'h0200, 1'b0);
    readyPat = 4'b1001;
    expIdx = 0;
    cyc = 0;
    while (expIdx < NUM_CEPS && cyc < 100) begin
      out_ready_i = readyPat[cyc % 4];
      checkOutput($sformatf("bp_valid_c%0d", cyc), 32'(out_valid_o), 32'd1);
      checkOutput($sformatf("bp_idx_c%0d", cyc), 32'(out_idx_o), 32'(expIdx));
      checkOutput($sformatf("bp_data_c%0d", cyc), 32'(out_data_o), 32'h0200 + 32'(expIdx));
      checkOutput($sformatf("bp_no_start_c%0d", cyc), 32'(start_frame_o), 32'd0);
      step(1);
      if (out_ready_i) expIdx++;
      cyc++;
    end
    checkOutput("bp_beats", 32'(expIdx), 32'(NUM_CEPS));
    checkOutput("bp_cycles", 32'(cyc), 32'd24);
    checkOutput("bp_frame_count", 32'(frame_count_o), 32'd2);
    checkOutput("bp_start_count", 32'(startCount), 32'd2);
    checkOutput("bp_idx_wrapped", 32'(out_idx_o), 32'd0);

    // Timeout: the held frame_ready starts the next frame, fft_done never arrives
    step(1);
    checkOutput("to_start_pulse", 32'(start_frame_o), 32'd1);
    frame_ready_i = 1'b0;
    step(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    step(TIMEOUT - 1);
    checkOutput("to_not_yet", 32'(error_o), 32'd0);
    step(1);
    checkOutput("to_error", 32'(error_o), 32'd1);
    checkOutput("to_code", 32'(error_code_o), 32'd1);
    checkOutput("to_busy", 32'(busy_o), 32'd0);
    step(3);
    checkOutput("to_code_holds", 32'(error_code_o), 32'd1);
    checkOutput("to_no_valid", 32'(out_valid_o), 32'd0);
    enable_i = 1'b0;
    step(1);
    checkOutput("to_exit_error", 32'(error_o), 32'd0);
    checkOutput("to_exit_code", 32'(error_code_o), 32'd0);
    checkOutput("to_frame_count", 32'(frame_count_o), 32'd2);

    // Sequence error: mel_done while waiting for fft_done
    enable_i = 1'b1;
    frame_ready_i = 1'b1;
    step(2);
    frame_ready_i = 1'b0;
    step(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("seq_error", 32'(error_o), 32'd1);
    checkOutput("seq_code", 32'(error_code_o), 32'd2);
    checkOutput("seq_frame_count", 32'(frame_count_o), 32'd2);
    enable_i = 1'b0;
    step(1);
    checkOutput("seq_exit_code", 32'(error_code_o), 32'd0);

    // Missing coefficients: index 11 never written, index 14 ignored
    enable_i = 1'b1;
    frame_ready_i = 1'b1;
    step(2);
    frame_ready_i = 1'b0;
    step(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    for (int p = 0; p < NUM_CEPS - 1; p++) begin
      applyStimulus(0, 0, 0, 0, 1, IDX_W'(p), 16'h0500 + 16'(p));
    end
    applyStimulus(0, 0, 0, 0, 1, 4'd14, 16'hDEAD);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("miss_error", 32'(error_o), 32'd1);
    checkOutput("miss_code", 32'(error_code_o), 32'd3);
    checkOutput("miss_frame_count", 32'(frame_count_o), 32'd2);
    enable_i = 1'b0;
    step(1);
    checkOutput("miss_exit_busy", 32'(busy_o), 32'd0);

    // Enable dropped in WAIT_MEL: frame still completes and drains, then IDLE
    enable_i = 1'b1;
    frame_ready_i = 1'b1;
    step(2);
    frame_ready_i = 1'b0;
    step(1);
    runStages(16'h0300, 1'b1);
    drainFull("stop", 16'h0300);
    checkOutput("stop_frame_count", 32'(frame_count_o), 32'd3);
    checkOutput("stop_idle", 32'(busy_o), 32'd0);
    checkOutput("stop_start_count", 32'(startCount), 32'd6);

    // Asynchronous reset in the middle of DRAIN
    enable_i = 1'b1;
    frame_ready_i = 1'b1;
    out_ready_i = 1'b0;
    step(2);
    frame_ready_i = 1'b0;
    step(1);
    runStages(16'h0400, 1'b0);
    out_ready_i = 1'b1;
    step(1);
    out_ready_i = 1'b0;
    checkOutput("rst_pre_idx", 32'(out_idx_o), 32'd1);
    checkOutput("rst_pre_data", 32'(out_data_o), 32'h0401);
    frame_ready_i = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("rst_async");
    step(2);
    checkOutput("rst_held_no_start", 32'(start_frame_o), 32'd0);
    enable_i = 1'b0;
    frame_ready_i = 1'b0;
    rst = 1'b0;
    step(2);
    checkOutput("rst_released_idle", 32'(busy_o), 32'd0);
    checkOutput("rst_start_count", 32'(startCount), 32'd7);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
